// File: rtl/alu_exec_pkg.sv
// Shared constants, types and helpers for the ALU execution unit.
// The imm8 scaling for the esp add/sub forms depends on the optional macro ALU_SLOT_SCALE_EN.
package alu_exec_pkg;

   localparam int NUM_PHASES = 12;
   localparam int DATA_W     = 32;
   localparam int LOAD_W     = 4;

   localparam logic [7:0] OP_PUSH_EBP = 8'h55;
   localparam logic [7:0] OP_POP_EBP  = 8'h5D;
   localparam logic [7:0] OP_GRP83    = 8'h83;
   localparam logic [7:0] OP_MOV      = 8'h89;
   localparam logic [7:0] OP_RET      = 8'hC3;
   localparam logic [7:0] OP_MOV_EAX  = 8'hB8;

   localparam logic [7:0] MODRM_SUB_ESP = 8'hEC;
   localparam logic [7:0] MODRM_ADD_ESP = 8'hC4;

   localparam logic [LOAD_W-1:0] LOAD_NONE = '0;

   // Bit indices into the phase vector (bit 0 = clock_1).
   localparam int PH_STEP1 = 3;
   localparam int PH_STEP2 = 5;
   localparam int PH_STEP3 = 7;
   localparam int PH_CLEAR = 9;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_1    = 2'd1,
      STEP_2    = 2'd2,
      STEP_3    = 2'd3
   } step_e;

   function automatic logic [DATA_W-1:0] scale_imm8(input logic [7:0] imm8);
`ifdef ALU_SLOT_SCALE_EN
      // The stack is addressed in 4-byte slots.
      return {24'h0, 2'b00, imm8[7:2]};
`else
      return {24'h0, imm8};
`endif
   endfunction

endpackage

// File: rtl/phase_ring.sv
// 12-phase one-hot instruction timing ring; idle (all zero) in reset,
// starts at clock_1 on the first edge after release.
module phase_ring
   import alu_exec_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [NUM_PHASES-1:0] phase
);

   // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (phase == '0) begin
         phase <= NUM_PHASES'(1);
      end else begin
         phase <= {phase[NUM_PHASES-2:0], phase[NUM_PHASES-1]};
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution core: phase timing plus up to three registered ALU steps per instruction.
// Optional macro ALU_SLOT_SCALE_EN scales imm8 of the esp add/sub forms to 4-byte slots.
module alu_exec_unit
   import alu_exec_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [NUM_PHASES-1:0] phase,
   input  logic [DATA_W-1:0]     ope,
   input  logic [DATA_W-1:0]     imm,
   input  logic [DATA_W-1:0]     operand,
   input  logic [3:0]            num_of_ope,
   input  logic [LOAD_W-1:0]     reg_load_1,
   input  logic [LOAD_W-1:0]     reg_load_2,
   input  logic [LOAD_W-1:0]     reg_load_3,
   output logic [DATA_W-1:0]     alu_result_bus,
   output logic [LOAD_W-1:0]     selected_reg_load
);

   logic [7:0]        opcode;
   logic [7:0]        modrm;
   logic [7:0]        imm8;
   step_e             step;
   logic [1:0]        steps_used;
   logic              step_en;
   logic [LOAD_W-1:0] load_next;
   logic [DATA_W-1:0] alu_next;
   logic              unused_ope_bits;

   assign opcode          = ope[31:24];
   assign modrm           = ope[23:16];
   assign imm8            = ope[15:8];
   assign unused_ope_bits = ^ope[7:0];

   phase_ring u_phase_ring (
      .clk   (clk),
      .reset (reset),
      .phase (phase)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      step       = STEP_NONE;
      load_next  = LOAD_NONE;
      alu_next   = operand + imm;
      steps_used = (num_of_ope > 4'd3) ? 2'd3 : num_of_ope[1:0];

      if (phase[PH_STEP1]) begin
         step      = STEP_1;
         load_next = reg_load_1;
      end else if (phase[PH_STEP2]) begin
         step      = STEP_2;
         load_next = reg_load_2;
      end else if (phase[PH_STEP3]) begin
         step      = STEP_3;
         load_next = reg_load_3;
      end

      step_en = (step != STEP_NONE) && (2'(step) <= steps_used);

      // First step of push pre-decrements esp; later steps of pop/ret post-increment.
      case (opcode)
         OP_PUSH_EBP: alu_next = (step == STEP_1) ? operand - 32'd1 : operand;
         OP_POP_EBP,
         OP_RET:      alu_next = (step == STEP_1) ? operand : operand + 32'd1;
         OP_GRP83: begin
            if (modrm == MODRM_SUB_ESP)      alu_next = operand - scale_imm8(imm8);
            else if (modrm == MODRM_ADD_ESP) alu_next = operand + scale_imm8(imm8);
            else                             alu_next = operand;
         end
         OP_MOV:      alu_next = operand;
         OP_MOV_EAX:  alu_next = {8'h00, ope[23:0]};
         default:     alu_next = operand + imm;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_bus    <= '0;
         selected_reg_load <= LOAD_NONE;
      end else if (step_en) begin
         alu_result_bus    <= alu_next;
         selected_reg_load <= load_next;
      end else if (phase[PH_CLEAR]) begin
         selected_reg_load <= LOAD_NONE;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expectations follow ALU_SLOT_SCALE_EN.
`timescale 1ns/1ps
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic [11:0] phase;
   logic [31:0] ope;
   logic [31:0] imm;
   logic [31:0] operand;
   logic [3:0]  num_of_ope;
   logic [3:0]  reg_load_1;
   logic [3:0]  reg_load_2;
   logic [3:0]  reg_load_3;
   logic [31:0] alu_result_bus;
   logic [3:0]  selected_reg_load;

   int n_checks = 0;
   int n_fail   = 0;

   alu_exec_unit dut (
      .clk               (clk),
      .reset             (reset),
      .phase             (phase),
      .ope               (ope),
      .imm               (imm),
      .operand           (operand),
      .num_of_ope        (num_of_ope),
      .reg_load_1        (reg_load_1),
      .reg_load_2        (reg_load_2),
      .reg_load_3        (reg_load_3),
      .alu_result_bus    (alu_result_bus),
      .selected_reg_load (selected_reg_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the negedge where phase[idx] is high, with a cycle budget.
   task automatic wait_phase(input int idx, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!phase[idx] && n < 30);
      if (!phase[idx]) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Drive operand during strobe idx, then sample just after the capturing edge.
   task automatic do_step(input int idx, input logic [31:0] val, input string tag);
      wait_phase(idx, tag);
      operand = val;
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] o, input logic [3:0] n,
                            input logic [3:0] l1, input logic [3:0] l2, input logic [3:0] l3);
      ope        = o;
      num_of_ope = n;
      reg_load_1 = l1;
      reg_load_2 = l2;
      reg_load_3 = l3;
   endtask

   logic [11:0] exp_ph;
   logic [31:0] exp_sub, exp_add;

   initial begin
`ifdef ALU_SLOT_SCALE_EN
      exp_sub = 32'h3E;
      exp_add = 32'h0;
`else
      exp_sub = 32'h38;
      exp_add = 32'h3;
`endif
      reset   = 1'b0;
      imm     = 32'h0;
      operand = 32'h0;
      set_instr(32'h0, 4'd0, 4'd0, 4'd0, 4'd0);

      #3;
      check("rst_phase", 32'(phase), 32'h0);
      check("rst_alu", alu_result_bus, 32'h0);
      check("rst_sel", 32'(selected_reg_load), 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold_phase", 32'(phase), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         #1;
         exp_ph = 12'h001 << (i % 12);
         check($sformatf("ring_%0d", i), 32'(phase), 32'(exp_ph));
         check($sformatf("onehot_%0d", i), 32'($onehot(phase)), 32'd1);
      end

      // push ebp, two steps
      set_instr(32'h5500_0000, 4'd2, 4'd3, 4'd5, 4'd7);
      do_step(3, 32'h10, "push1");
      check("push1_alu", alu_result_bus, 32'h0F);
      check("push1_sel", 32'(selected_reg_load), 32'h3);
      check("push1_phase5", 32'(phase), 32'h010);
      do_step(5, 32'h20, "push2");
      check("push2_alu", alu_result_bus, 32'h20);
      check("push2_sel", 32'(selected_reg_load), 32'h5);
      do_step(7, 32'h99, "push3");
      check("push3_hold_alu", alu_result_bus, 32'h20);
      check("push3_hold_sel", 32'(selected_reg_load), 32'h5);
      do_step(9, 32'h0, "push_clr");
      check("push_clr_sel", 32'(selected_reg_load), 32'h0);
      check("push_clr_alu", alu_result_bus, 32'h20);

      // sub esp, 8
      set_instr(32'h83EC_0800, 4'd1, 4'd2, 4'd6, 4'd0);
      do_step(3, 32'h40, "sub1");
      check("sub_alu", alu_result_bus, exp_sub);
      check("sub_sel", 32'(selected_reg_load), 32'h2);
      do_step(5, 32'h77, "sub2");
      check("sub2_hold_alu", alu_result_bus, exp_sub);
      check("sub2_hold_sel", 32'(selected_reg_load), 32'h2);

      // add esp, 4 with wrap
      set_instr(32'h83C4_0400, 4'd1, 4'd4, 4'd0, 4'd0);
      do_step(3, 32'hFFFF_FFFF, "add1");
      check("add_wrap_alu", alu_result_bus, exp_add);
      check("add_sel", 32'(selected_reg_load), 32'h4);

      // mov eax, imm
      set_instr(32'hB800_1234, 4'd1, 4'd6, 4'd0, 4'd0);
      do_step(3, 32'h0000_DEAD, "moveax");
      check("moveax_alu", alu_result_bus, 32'h0000_1234);
      check("moveax_sel", 32'(selected_reg_load), 32'h6);

      // num_of_ope = 0: nothing updates
      set_instr(32'h0100_0000, 4'd0, 4'd9, 4'd9, 4'd9);
      do_step(3, 32'h0000_BEEF, "none1");
      check("none1_alu", alu_result_bus, 32'h0000_1234);
      check("none1_sel", 32'(selected_reg_load), 32'h0);
      do_step(5, 32'h0000_BEEF, "none2");
      check("none2_alu", alu_result_bus, 32'h0000_1234);

      // pop ebp with increment wrap
      set_instr(32'h5D00_0000, 4'd2, 4'd1, 4'd2, 4'd0);
      do_step(3, 32'h30, "pop1");
      check("pop1_alu", alu_result_bus, 32'h30);
      check("pop1_sel", 32'(selected_reg_load), 32'h1);
      do_step(5, 32'hFFFF_FFFF, "pop2");
      check("pop2_wrap_alu", alu_result_bus, 32'h0);
      check("pop2_sel", 32'(selected_reg_load), 32'h2);

      // default op, num_of_ope > 3 treated as 3, nonzero imm
      imm = 32'h5;
      set_instr(32'h0100_0000, 4'd4, 4'd7, 4'd8, 4'd9);
      do_step(3, 32'h0, "def1");
      check("def1_alu", alu_result_bus, 32'h5);
      do_step(5, 32'h10, "def2");
      check("def2_alu", alu_result_bus, 32'h15);
      check("def2_sel", 32'(selected_reg_load), 32'h8);
      do_step(7, 32'h100, "def3");
      check("def3_alu", alu_result_bus, 32'h105);
      check("def3_sel", 32'(selected_reg_load), 32'h9);
      imm = 32'h0;

      // ret
      set_instr(32'hC300_0000, 4'd2, 4'd1, 4'd1, 4'd0);
      do_step(3, 32'h0000_0400, "ret1");
      check("ret1_alu", alu_result_bus, 32'h0000_0400);
      do_step(5, 32'h0000_01FF, "ret2");
      check("ret2_alu", alu_result_bus, 32'h0000_0200);

      // mov, then reset asserted during phase 6
      set_instr(32'h8900_0000, 4'd1, 4'd3, 4'd0, 4'd0);
      do_step(3, 32'h0000_0ABC, "mov1");
      check("mov_alu", alu_result_bus, 32'h0000_0ABC);
      wait_phase(5, "abort");
      #2 reset = 1'b0;
      #1;
      check("abort_phase", 32'(phase), 32'h0);
      check("abort_alu", alu_result_bus, 32'h0);
      check("abort_sel", 32'(selected_reg_load), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("restart_phase", 32'(phase), 32'h001);
      @(posedge clk);
      #1;
      check("restart_phase2", 32'(phase), 32'h002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
